// File: rtl/imm_extend_pipe_if.sv
// Request/response bundle for the immediate-extension pipeline.
// The master drives requests and consumes results; the slave is the unit itself.
interface imm_extend_pipe_if #(
    parameter int IMM_W     = 26,
    parameter int DATA_W    = 32,
    parameter int ERR_CNT_W = 8
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [IMM_W-1:0]     imm;
    logic [1:0]           imm_src;
    logic                 sign_en;
    logic [1:0]           shamt;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    ext_imm;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, imm, imm_src, sign_en, shamt, out_ready,
        input  in_ready, out_valid, ext_imm, out_err, err_cnt
    );

    modport slave (
        input  in_valid, imm, imm_src, sign_en, shamt, out_ready,
        output in_ready, out_valid, ext_imm, out_err, err_cnt
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate-extension unit: S1 captures the selected field and
// controls, S2 applies sign/zero extension plus the scaling shift. A
// combinational ready chain gives full throughput under a valid/ready protocol.
module imm_extend_pipe #(
    parameter int DATA_W    = 32,
    parameter int IMM_W     = 26,
    parameter int W0        = 13,
    parameter int W1        = 17,
    parameter int W2        = 26,
    parameter int ERR_CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    imm_extend_pipe_if.slave   bus
);

    generate
        if (!(1 <= W0 && W0 <= W1 && W1 <= W2 && W2 <= IMM_W && IMM_W <= DATA_W)) begin : g_bad_params
            $error("imm_extend_pipe: width parameters must satisfy 1 <= W0 <= W1 <= W2 <= IMM_W <= DATA_W");
        end
    endgenerate

    // Field masks in the raw-immediate domain and in the output domain.
    localparam logic [IMM_W-1:0]     FMASK0  = {IMM_W{1'b1}} >> (IMM_W - W0);
    localparam logic [IMM_W-1:0]     FMASK1  = {IMM_W{1'b1}} >> (IMM_W - W1);
    localparam logic [IMM_W-1:0]     FMASK2  = {IMM_W{1'b1}} >> (IMM_W - W2);
    localparam logic [DATA_W-1:0]    DMASK0  = {DATA_W{1'b1}} >> (DATA_W - W0);
    localparam logic [DATA_W-1:0]    DMASK1  = {DATA_W{1'b1}} >> (DATA_W - W1);
    localparam logic [DATA_W-1:0]    DMASK2  = {DATA_W{1'b1}} >> (DATA_W - W2);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    // Widen a zero-padded field to DATA_W, fill the upper bits from the field
    // MSB when sign extension is requested, then shift; overflow bits drop off.
    function automatic logic [DATA_W-1:0] extend_shift(
        input logic [IMM_W-1:0] field,
        input logic [1:0]       wsel,
        input logic             sgn,
        input logic [1:0]       sh
    );
        logic [DATA_W-1:0] wide;
        logic [DATA_W-1:0] dmask;
        logic              msb;
        wide = DATA_W'(field);
        case (wsel)
            2'b00:   begin dmask = DMASK0; msb = field[W0-1]; end
            2'b01:   begin dmask = DMASK1; msb = field[W1-1]; end
            2'b10:   begin dmask = DMASK2; msb = field[W2-1]; end
            default: begin dmask = {DATA_W{1'b1}}; msb = 1'b0; end
        endcase
        if (sgn && msb) begin
            wide = wide | ~dmask;
        end else begin
            wide = wide;
        end
        return wide << sh;
    endfunction

    logic                 s1_valid_r;
    logic [IMM_W-1:0]     s1_field_r;
    logic [1:0]           s1_wsel_r;
    logic                 s1_sign_r;
    logic [1:0]           s1_shamt_r;
    logic                 s1_err_r;
    logic                 s2_valid_r;
    logic [DATA_W-1:0]    ext_imm_r;
    logic                 out_err_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;

    logic                 s2_adv_s;
    logic                 s1_adv_s;
    logic                 in_fire_s;
    logic                 in_rsvd_s;
    logic [IMM_W-1:0]     field_s;

    assign s2_adv_s  = !s2_valid_r || bus.out_ready;
    assign s1_adv_s  = !s1_valid_r || s2_adv_s;
    assign in_fire_s = bus.in_valid && s1_adv_s;
    assign in_rsvd_s = (bus.imm_src == 2'b11);

    assign bus.in_ready  = s1_adv_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.ext_imm   = ext_imm_r;
    assign bus.out_err   = out_err_r;
    assign bus.err_cnt   = err_cnt_r;

    // Isolate the selected immediate field, zero-padded to IMM_W.
    always_comb begin
        field_s = {IMM_W{1'b0}};
        case (bus.imm_src)
            2'b00:   field_s = bus.imm & FMASK0;
            2'b01:   field_s = bus.imm & FMASK1;
            2'b10:   field_s = bus.imm & FMASK2;
            default: field_s = {IMM_W{1'b0}};
        endcase
    end

    // Stage 1: capture field and controls on each input transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_field_r <= {IMM_W{1'b0}};
            s1_wsel_r  <= 2'b00;
            s1_sign_r  <= 1'b0;
            s1_shamt_r <= 2'b00;
            s1_err_r   <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= bus.in_valid;
            if (in_fire_s) begin
                s1_field_r <= field_s;
                s1_wsel_r  <= bus.imm_src;
                s1_sign_r  <= bus.sign_en;
                s1_shamt_r <= bus.shamt;
                s1_err_r   <= in_rsvd_s;
            end
        end
    end

    // Stage 2: compute and hold the final result; frozen while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            ext_imm_r  <= {DATA_W{1'b0}};
            out_err_r  <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                ext_imm_r <= s1_err_r ? {DATA_W{1'b0}}
                                      : extend_shift(s1_field_r, s1_wsel_r, s1_sign_r, s1_shamt_r);
                out_err_r <= s1_err_r;
            end
        end
    end

    // Saturating count of accepted reserved-encoding requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if (in_fire_s && in_rsvd_s && (err_cnt_r != ERR_MAX)) begin
            err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed table, backpressure/throughput/reset
// sequences, randomized traffic against an arithmetic reference model, and a
// narrow parametrised instance.
module tb_imm_extend_pipe;

    typedef struct {
        logic [25:0] imm;
        logic [1:0]  src;
        logic        sgn;
        logic [1:0]  sh;
        logic [31:0] exp_ext;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] ext;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;

    imm_extend_pipe_if #(.IMM_W(26), .DATA_W(32), .ERR_CNT_W(8)) bus ();
    imm_extend_pipe_if #(.IMM_W(16), .DATA_W(16), .ERR_CNT_W(8)) bus16 ();

    imm_extend_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    imm_extend_pipe #(
        .DATA_W(16), .IMM_W(16), .W0(8), .W1(12), .W2(16), .ERR_CNT_W(8)
    ) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          n_acc       = 0;
    int          n_out       = 0;
    int          n_stall_in  = 0;
    int          ref_err     = 0;
    bit          auto_push   = 1'b1;
    bit          prev_stall  = 1'b0;
    logic [31:0] prev_ext;
    logic        prev_err;
    exp_t        exp_q[$];
    vec_t        tbl[12];

    // Reference: take imm modulo 2^W, reinterpret as signed if requested,
    // multiply by 2^shamt and keep the low 32 bits.
    function automatic logic [31:0] ref_ext(input logic [25:0] imm, input logic [1:0] src,
                                            input logic sgn, input logic [1:0] sh);
        int     w;
        longint f;
        longint v;
        if (src == 2'd3) return 32'd0;
        w = (src == 2'd0) ? 13 : (src == 2'd1) ? 17 : 26;
        f = longint'(imm) % (longint'(1) << w);
        v = (sgn && f >= (longint'(1) << (w - 1))) ? f - (longint'(1) << w) : f;
        v = v * (longint'(1) << sh);
        return v[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of observation, entered and left at a falling edge.
    task automatic cycle();
        exp_t e;
        #1;
        if (bus.out_valid && !bus.out_ready) begin
            if (prev_stall) begin
                chk("hold_ext", bus.ext_imm, prev_ext);
                chk("hold_err", {31'd0, bus.out_err}, {31'd0, prev_err});
            end
            prev_stall = 1'b1;
            prev_ext   = bus.ext_imm;
            prev_err   = bus.out_err;
        end else begin
            prev_stall = 1'b0;
        end
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ext_imm", bus.ext_imm, e.ext);
                chk("out_err", {31'd0, bus.out_err}, {31'd0, e.err});
            end
        end
        if (bus.in_valid && !bus.in_ready) n_stall_in++;
        if (bus.in_valid && bus.in_ready) begin
            n_acc++;
            if (bus.imm_src == 2'b11 && ref_err < 255) ref_err++;
            if (auto_push) exp_q.push_back('{ref_ext(bus.imm, bus.imm_src, bus.sign_en, bus.shamt),
                                             bus.imm_src == 2'b11});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        exp_q.delete();
        ref_err    = 0;
        prev_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive(input logic [25:0] imm, input logic [1:0] src, input logic sgn, input logic [1:0] sh);
        bus.imm     = imm;
        bus.imm_src = src;
        bus.sign_en = sgn;
        bus.shamt   = sh;
    endtask

    initial begin
        int          base_out;
        int          base_acc;
        int          base_stall;
        int          k;
        logic [25:0] bp_imm[5];

        tbl[0]  = '{26'h0001000, 2'b00, 1'b1, 2'd0, 32'hFFFFF000, 1'b0};
        tbl[1]  = '{26'h0001000, 2'b00, 1'b0, 2'd0, 32'h00001000, 1'b0};
        tbl[2]  = '{26'h0010000, 2'b01, 1'b1, 2'd0, 32'hFFFF0000, 1'b0};
        tbl[3]  = '{26'h2000000, 2'b10, 1'b1, 2'd0, 32'hFE000000, 1'b0};
        tbl[4]  = '{26'h2000000, 2'b10, 1'b1, 2'd2, 32'hF8000000, 1'b0};
        tbl[5]  = '{26'h3FFFFFF, 2'b10, 1'b1, 2'd0, 32'hFFFFFFFF, 1'b0};
        tbl[6]  = '{26'h3FFFFFF, 2'b10, 1'b1, 2'd3, 32'hFFFFFFF8, 1'b0};
        tbl[7]  = '{26'h3FFFFFF, 2'b01, 1'b0, 2'd0, 32'h0001FFFF, 1'b0};
        tbl[8]  = '{26'h0000FFF, 2'b00, 1'b1, 2'd0, 32'h00000FFF, 1'b0};
        tbl[9]  = '{26'h3FFFFFF, 2'b00, 1'b0, 2'd1, 32'h00003FFE, 1'b0};
        tbl[10] = '{26'h3FFFFFF, 2'b11, 1'b1, 2'd3, 32'h00000000, 1'b1};
        tbl[11] = '{26'h1FFFFFF, 2'b10, 1'b1, 2'd3, 32'h0FFFFFF8, 1'b0};

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        drive(26'd0, 2'b00, 1'b0, 2'd0);
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
        bus16.imm = 16'd0; bus16.imm_src = 2'b00; bus16.sign_en = 1'b0; bus16.shamt = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_ext_imm", bus.ext_imm, 32'd0);
        chk("rst_out_err", {31'd0, bus.out_err}, 32'd0);
        chk("rst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        reset = 1'b0;

        // Directed table, one request at a time, checking 2-cycle latency.
        auto_push = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].imm, tbl[i].src, tbl[i].sgn, tbl[i].sh);
            bus.in_valid = 1'b1;
            exp_q.push_back('{tbl[i].exp_ext, tbl[i].exp_err});
            cycle();
            bus.in_valid = 1'b0;
            #1 chk("latency_early", {31'd0, bus.out_valid}, 32'd0);
            cycle();
            #1 chk("latency_2", {31'd0, bus.out_valid}, 32'd1);
            cycle();
        end
        auto_push = 1'b1;

        // Backpressure: 5 back-to-back requests, out_ready low in cycles 3..6.
        do_reset();
        for (int i = 0; i < 5; i++) bp_imm[i] = 26'($urandom);
        base_out = n_out; base_acc = n_acc; base_stall = n_stall_in;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            k = n_acc - base_acc;
            bus.out_ready = !(cyc >= 3 && cyc <= 6);
            bus.in_valid  = (k < 5);
            if (k < 5) drive(bp_imm[k], 2'(k % 3), 1'b1, 2'(k % 4));
            cycle();
        end
        bus.in_valid = 1'b0;
        chk("bp_count", 32'(n_out - base_out), 32'd5);
        chk("bp_leftover", 32'(exp_q.size()), 32'd0);
        chk("bp_in_ready_dropped", {31'd0, (n_stall_in > base_stall)}, 32'd1);

        // Throughput: 8 requests with out_ready high give 8 results in 10 cycles.
        base_out = n_out; base_stall = n_stall_in;
        bus.out_ready = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            bus.in_valid = (cyc <= 8);
            drive(26'($urandom), 2'($urandom_range(0, 2)), 1'($urandom), 2'($urandom));
            cycle();
        end
        bus.in_valid = 1'b0;
        chk("tp_count", 32'(n_out - base_out), 32'd8);
        chk("tp_no_stall", 32'(n_stall_in - base_stall), 32'd0);

        // Reserved encodings: count of 3, then saturation at 255.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 303; i++) begin
            bus.in_valid = 1'b1;
            drive(26'($urandom), 2'b11, 1'($urandom), 2'($urandom));
            cycle();
            if (i == 2) begin
                bus.in_valid = 1'b0;
                cycle(); cycle();
                chk("err_cnt_3", {24'd0, bus.err_cnt}, 32'd3);
            end
        end
        bus.in_valid = 1'b0;
        cycle(); cycle();
        chk("err_cnt_sat", {24'd0, bus.err_cnt}, 32'd255);

        // Reset with both stages full; nothing may emerge afterwards.
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(26'h0000001, 2'b11, 1'b0, 2'd0);
        cycle(); cycle();
        chk("mid_err_cnt", {24'd0, bus.err_cnt}, 32'd2);
        chk("mid_full", {31'd0, bus.in_ready}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("arst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
        exp_q.delete(); ref_err = 0; prev_stall = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_ignores_valid", {24'd0, bus.err_cnt}, 32'd0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        base_out = n_out;
        repeat (5) cycle();
        chk("no_stale", 32'(n_out - base_out), 32'd0);

        // Randomized traffic with random backpressure.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            drive(26'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 2'($urandom));
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle();
        chk("rand_drain", 32'(exp_q.size()), 32'd0);
        chk("rand_err_cnt", {24'd0, bus.err_cnt}, 32'(ref_err));

        // Narrow instance: 8-bit field extended to 16 bits.
        for (int j = 0; j < 2; j++) begin
            bus16.imm = 16'h0080; bus16.imm_src = 2'b00;
            bus16.sign_en = (j == 0); bus16.shamt = 2'd0;
            bus16.out_ready = 1'b1; bus16.in_valid = 1'b1;
            @(posedge clk); @(negedge clk);
            bus16.in_valid = 1'b0;
            for (int t = 0; t < 6 && !bus16.out_valid; t++) begin
                @(posedge clk); @(negedge clk);
            end
            chk("w16_valid", {31'd0, bus16.out_valid}, 32'd1);
            chk("w16_ext", {16'd0, bus16.ext_imm}, (j == 0) ? 32'h0000FF80 : 32'h00000080);
            @(posedge clk); @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, pipelined immediate-extension unit for the PDA core's decode/execute boundary.
- Selects one of three immediate field widths.
- Applies sign or zero extension to DATA_W.
- Applies an optional left shift for word/halfword-scaled offsets.
- Uses a valid/ready handshake with full throughput, so decode stalls propagate cleanly.
- Flags reserved encodings and counts them in a saturating error counter for debug.

Parameters:
DATA_W, 32, output datapath width
IMM_W, 26, width of raw immediate input
W0, 13, field width for imm_src=00
W1, 17, field width for imm_src=01
W2, 26, field width for imm_src=10
ERR_CNT_W, 8, width of reserved-encoding error counter
Legal-range constraint (elaboration check): 1 <= W0 <= W1 <= W2 <= IMM_W <= DATA_W.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request this cycle
imm  input  IMM_W  raw immediate from instruction
imm_src  input  2  field select: 00=W0, 01=W1, 10=W2, 11=reserved
sign_en  input  1  1=sign-extend, 0=zero-extend
shamt  input  2  left shift 0..3 applied after extension
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
ext_imm  output  DATA_W  extended, shifted immediate
out_err  output  1  result came from reserved imm_src
err_cnt  output  ERR_CNT_W  count of accepted reserved requests, saturating

Behaviour:
- Reset (async assert, sync deassert at next clk): s1_valid=0, s2_valid=0, out_valid=0, ext_imm=0, out_err=0, err_cnt=0. Any in-flight request is discarded; nothing is emitted after reset.
- Transfer rules:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
- Stage 1 (S1) registers the field (imm[Wn-1:0] zero-padded to IMM_W), its width select, sign_en, shamt, and an err bit (imm_src==11).
- Stage 2 (S2) registers the final result, driving ext_imm, out_err and out_valid=s2_valid.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 per cycle.
- Ready chain:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv
  - Combinational, no bubbles.
- Stall: while out_valid && !out_ready, ext_imm and out_err hold stable and S1 holds if full.
- Extension arithmetic:
  - Select field width Wn.
  - If sign_en, replicate bit imm[Wn-1] into bits DATA_W-1..Wn; otherwise fill with 0.
  - Then shift left by shamt; bits shifted past DATA_W-1 are discarded (truncate, no saturation).
- Reserved imm_src=11: ext_imm=0, out_err=1; still consumes one pipeline slot and completes a normal handshake.
- err_cnt increments by 1 on each input transfer with imm_src==11 and saturates at 2^ERR_CNT_W-1 (never wraps).
- Simultaneous events: input and output transfers in the same cycle are both honoured, and occupancy is unchanged.
- Inputs are sampled only on transfer. Changes to imm/imm_src while in_ready=0 have no effect.
- in_valid while reset is high is ignored.

Test Plan:
- Directed sign/zero across all three widths, each with no stall, shamt=0, result 2 cycles after accept:
  - imm=26'h0001000, imm_src=00, sign_en=1 -> ext_imm=32'hFFFFF000
  - same imm with sign_en=0 -> 32'h00001000
  - imm=26'h0010000, imm_src=01, sign_en=1 -> 32'hFFFF0000
  - imm=26'h2000000, imm_src=10, sign_en=1 -> 32'hFE000000
- Shift/truncate: imm=26'h2000000, src=10, sign_en=1, shamt=2 -> 32'hF8000000; imm=26'h3FFFFFF, shamt=0 -> 32'hFFFFFFFF; shamt=3 -> 32'hFFFFFFF8.
- Backpressure and throughput:
  - Stream 5 back-to-back requests with out_ready low for cycles 3-6: in_ready drops once S1 and S2 are full, ext_imm holds stable, all 5 results emerge in order with no loss or duplication.
  - With out_ready=1 throughout, one result per cycle.
- Reserved encoding: 3 requests with imm_src=11 -> each gives ext_imm=0, out_err=1, err_cnt=3. Preload via 300 requests -> err_cnt saturates at 255.
- Reset mid-operation: assert reset with both stages full -> out_valid=0, in_ready=1, err_cnt=0 immediately (async). No stale result appears after deassertion.
- Parametrised instance W0=8, W1=12, W2=16, IMM_W=16, DATA_W=16: imm=16'h0080, src=00, sign_en=1 -> 16'hFF80.
